// File: rtl/truth_table_scanner_if.sv
// Signal bundle between a truth-table scanner and whoever supplies the
// expected mask, the start pulse and the response of the block under scan.
interface truth_table_scanner_if;
    logic        start;
    logic        dut_out;
    logic [15:0] expected;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;

    // Controller / stimulus side
    modport master (
        output start, dut_out, expected,
        input  vec, busy, done, table_out, pass, mismatch_count, first_fail
    );

    // Scanner side
    modport slave (
        input  start, dut_out, expected,
        output vec, busy, done, table_out, pass, mismatch_count, first_fail
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks a 4-input function block through all 16 input vectors, captures
// its (optionally registered) response and grades it against an expected
// truth table: pass flag, mismatch count and lowest failing minterm.
module truth_table_scanner #(
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    truth_table_scanner_if.slave  bus
);

    localparam int unsigned D  = LATENCY + 1;
    localparam int unsigned IW = 4 * D;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic   [3:0]    vec_q;
    logic   [15:0]   table_q;
    logic            pass_q;
    logic   [4:0]    mismatch_q;
    logic   [3:0]    first_fail_q;

    // Capture pipeline: valid bits and the vector index each response belongs to,
    // newest entry in the low slot, oldest (about to be captured) in the top slot.
    logic   [D-1:0]  pipe_v;
    logic   [IW-1:0] pipe_idx;

    logic            load_v;
    logic   [3:0]    load_idx;
    logic            start_scan;
    logic            cap_v;
    logic   [3:0]    cap_k;
    logic            cap_miss;
    logic   [4:0]    mm_next;
    logic            finish;

    assign cap_v    = pipe_v[D-1];
    assign cap_k    = pipe_idx[IW-1 -: 4];
    assign cap_miss = cap_v && (bus.dut_out != bus.expected[cap_k]);
    assign mm_next  = mismatch_q + 5'(cap_miss);
    assign finish   = (state_q == DRAIN) && cap_v && (cap_k == 4'd15);

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and vector issue control
    always_comb begin
        state_d    = state_q;
        load_v     = 1'b0;
        load_idx   = 4'd0;
        start_scan = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = DRIVE;
                    load_v     = 1'b1;
                    start_scan = 1'b1;
                end
            end
            DRIVE: begin
                load_v   = 1'b1;
                load_idx = vec_q + 4'd1;
                if (vec_q == 4'd14) state_d = DRAIN;
            end
            DRAIN: begin
                if (finish) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector counter, capture pipeline and result accumulation
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pipe_v       <= '0;
            pipe_idx     <= '0;
            vec_q        <= '0;
            table_q      <= '0;
            pass_q       <= 1'b0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
        end else begin
            pipe_v   <= (pipe_v << 1) | D'(load_v);
            pipe_idx <= (pipe_idx << 4) | IW'(load_idx);
            if (start_scan) begin
                vec_q        <= '0;
                table_q      <= '0;
                pass_q       <= 1'b0;
                mismatch_q   <= '0;
                first_fail_q <= '0;
            end else begin
                if (state_q == DRIVE) vec_q <= load_idx;
                if (cap_v) begin
                    table_q[cap_k] <= bus.dut_out;
                    mismatch_q     <= mm_next;
                    // A zero count before this capture means no earlier miss in this scan.
                    if (cap_miss && (mismatch_q == 5'd0)) first_fail_q <= cap_k;
                end
                if (finish) pass_q <= (mm_next == 5'd0);
            end
        end
    end

    assign bus.vec            = vec_q;
    assign bus.busy           = (state_q == DRIVE) || (state_q == DRAIN);
    assign bus.done           = (state_q == DONE);
    assign bus.table_out      = table_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three scanners (LATENCY 0, 1, 3) scan the
// same function concurrently, each fed by its own model of the block under
// scan, and are graded against a truth-table reference model.
module tb_truth_table_scanner;

    localparam int LAT [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [15:0] fn_tt;
    logic [15:0] exp_mask;

    always #5 clk = ~clk;

    truth_table_scanner_if bus0 ();
    truth_table_scanner_if bus1 ();
    truth_table_scanner_if bus3 ();

    truth_table_scanner #(.LATENCY(0)) u_l0 (.clk(clk), .clr_n(clr_n), .bus(bus0.slave));
    truth_table_scanner #(.LATENCY(1)) u_l1 (.clk(clk), .clr_n(clr_n), .bus(bus1.slave));
    truth_table_scanner #(.LATENCY(3)) u_l3 (.clk(clk), .clr_n(clr_n), .bus(bus3.slave));

    assign bus0.start = start;  assign bus0.expected = exp_mask;
    assign bus1.start = start;  assign bus1.expected = exp_mask;
    assign bus3.start = start;  assign bus3.expected = exp_mask;

    // Blocks under scan: the function fn_tt behind 0, 1 and 3 register stages
    logic       q1;
    logic [2:0] q3;
    assign bus0.dut_out = fn_tt[bus0.vec];
    always_ff @(posedge clk) q1 <= fn_tt[bus1.vec];
    assign bus1.dut_out = q1;
    always_ff @(posedge clk) q3 <= {q3[1:0], fn_tt[bus3.vec]};
    assign bus3.dut_out = q3[2];

    logic [3:0]  vec_a  [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic        pass_a [3];
    logic [15:0] tab_a  [3];
    logic [4:0]  mm_a   [3];
    logic [3:0]  ff_a   [3];

    assign vec_a[0] = bus0.vec;  assign busy_a[0] = bus0.busy;  assign done_a[0] = bus0.done;
    assign pass_a[0] = bus0.pass; assign tab_a[0] = bus0.table_out;
    assign mm_a[0] = bus0.mismatch_count; assign ff_a[0] = bus0.first_fail;
    assign vec_a[1] = bus1.vec;  assign busy_a[1] = bus1.busy;  assign done_a[1] = bus1.done;
    assign pass_a[1] = bus1.pass; assign tab_a[1] = bus1.table_out;
    assign mm_a[1] = bus1.mismatch_count; assign ff_a[1] = bus1.first_fail;
    assign vec_a[2] = bus3.vec;  assign busy_a[2] = bus3.busy;  assign done_a[2] = bus3.done;
    assign pass_a[2] = bus3.pass; assign tab_a[2] = bus3.table_out;
    assign mm_a[2] = bus3.mismatch_count; assign ff_a[2] = bus3.first_fail;

    int n_checks = 0;
    int n_pass   = 0;
    int done_edge [3];
    int vec_bad   [3];

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  mm;
        logic [3:0]  ff;
    } result_t;

    typedef struct {
        logic [15:0] tt;
        logic [15:0] e;
        logic [15:0] want_tbl;
        logic        want_pass;
        logic [4:0]  want_mm;
        logic [3:0]  want_ff;
        int          pulse;
    } dir_t;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s (LATENCY=%0d): got %0h, want %0h", name, LAT[inst], act, want);
    endtask

    // Reference: the captured table is the function's truth table; grading is
    // a bitwise difference against the expected mask.
    function automatic result_t model(input logic [15:0] tt, input logic [15:0] e);
        result_t     r;
        logic [15:0] diff;
        diff   = tt ^ e;
        r.tbl  = tt;
        r.mm   = 5'($countones(diff));
        r.pass = (diff == 16'h0);
        r.ff   = 4'd0;
        for (int m = 15; m >= 0; m--) if (diff[m]) r.ff = 4'(m);
        return r;
    endfunction

    task automatic check_zero(input string name);
        for (int i = 0; i < 3; i++)
            check(name, i, 32'({vec_a[i], busy_a[i], done_a[i], tab_a[i], pass_a[i], mm_a[i], ff_a[i]}), 32'h0);
    endtask

    // Start a scan at edge 0 and follow it edge by edge; optional second start
    // pulse sampled at edge pulse_edge, optional reset after edge abort_edge.
    task automatic run_scan(input logic [15:0] tt, input logic [15:0] e,
                            input int pulse_edge, input int abort_edge, output bit aborted);
        aborted = 1'b0;
        @(negedge clk);
        fn_tt    = tt;
        exp_mask = e;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("edge0_busy", i, 32'(busy_a[i]), 32'd1);
            check("edge0_done_pass", i, 32'({done_a[i], pass_a[i]}), 32'd0);
            check("edge0_cleared", i, 32'({vec_a[i], tab_a[i], mm_a[i], ff_a[i]}), 32'd0);
            done_edge[i] = -1;
            vec_bad[i]   = 0;
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_edge[i] < 0 && done_a[i] === 1'b1) done_edge[i] = c;
                if (vec_a[i] !== 4'((c <= 15) ? c : 15)) vec_bad[i]++;
            end
            if (c == abort_edge) begin
                for (int i = 0; i < 3; i++) check("vec_before_reset", i, 32'(vec_bad[i]), 32'd0);
                clr_n = 1'b0;
                #1;
                check_zero("async_reset");
                @(negedge clk);
                check_zero("held_in_reset");
                clr_n   = 1'b1;
                aborted = 1'b1;
                return;
            end
            start = (c + 1 == pulse_edge);
        end
        start = 1'b0;
    endtask

    task automatic check_results(input result_t w);
        for (int i = 0; i < 3; i++) begin
            check("done_edge", i, 32'(done_edge[i]), 32'(16 + LAT[i]));
            check("vec_sequence", i, 32'(vec_bad[i]), 32'd0);
            check("busy_after", i, 32'(busy_a[i]), 32'd0);
            check("table_out", i, 32'(tab_a[i]), 32'(w.tbl));
            check("pass", i, 32'(pass_a[i]), 32'(w.pass));
            check("mismatch_count", i, 32'(mm_a[i]), 32'(w.mm));
            check("first_fail", i, 32'(ff_a[i]), 32'(w.ff));
        end
    endtask

    initial begin
        dir_t        dir [9];
        result_t     w;
        bit          ab;
        logic [15:0] tt, e;

        // {function table, expected, table, pass, mismatches, first fail, restart pulse edge}
        dir[0] = '{16'hFF00, 16'hFF00, 16'hFF00, 1'b1, 5'd0,  4'd0,  -1}; // flop of a
        dir[1] = '{16'hFF00, 16'h0000, 16'hFF00, 1'b0, 5'd8,  4'd8,  -1}; // restart from DONE
        dir[2] = '{16'hFF00, 16'hFF00, 16'hFF00, 1'b1, 5'd0,  4'd0,   5}; // start while busy
        dir[3] = '{16'hFF00, 16'hFF05, 16'hFF00, 1'b0, 5'd2,  4'd0,  -1};
        dir[4] = '{16'h6996, 16'h6996, 16'h6996, 1'b1, 5'd0,  4'd0,  -1}; // a^b^c^d
        dir[5] = '{16'h6996, 16'h6990, 16'h6996, 1'b0, 5'd2,  4'd1,  -1};
        dir[6] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 4'd0,  -1}; // every bit wrong
        dir[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 5'd0,  4'd0,  -1};
        dir[8] = '{16'hAAAA, 16'h2AAA, 16'hAAAA, 1'b0, 5'd1,  4'd15, -1}; // only m=15 wrong

        clr_n    = 1'b0;
        start    = 1'b0;
        fn_tt    = 16'h0;
        exp_mask = 16'h0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        clr_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 9; n++) begin
            run_scan(dir[n].tt, dir[n].e, dir[n].pulse, -1, ab);
            w.tbl  = dir[n].want_tbl;
            w.pass = dir[n].want_pass;
            w.mm   = dir[n].want_mm;
            w.ff   = dir[n].want_ff;
            check_results(w);
        end

        // Reset mid-scan at vec=7, then a fresh scan must carry no stale bits
        run_scan(16'hFFFF, 16'hFFFF, -1, 7, ab);
        repeat (4) @(negedge clk);
        run_scan(16'h1234, 16'h1204, -1, -1, ab);
        check_results(model(16'h1234, 16'h1204));

        for (int n = 0; n < 16; n++) begin
            tt = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       e = tt;
                1:       e = tt ^ (16'h1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            run_scan(tt, e, -1, -1, ab);
            check_results(model(tt, e));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
